// File: rtl/regbus_master.sv
// Burst initiator for the 9-bit address / 8-bit data register bus.
// Turns burst commands into single-cycle read/write strobes, streams write data in and read data out.
module regbus_master (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [8:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic       cmd_incr,
    input  logic       wdat_valid,
    output logic       wdat_ready,
    input  logic [7:0] wdat_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [8:0] a,
    output logic [7:0] d_d,
    input  logic [7:0] d_q,
    output logic       read_strobe,
    output logic       write_strobe
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_RESP  = 3'd4
    } state_t;

    state_t     state_q;
    logic [8:0] addr_q;
    logic [3:0] cnt_q;
    logic [3:0] len_q;
    logic       incr_q;
    logic [8:0] a_q;
    logic [7:0] wr_data_q;
    logic       rd_strobe_q;
    logic       wr_strobe_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;

    logic [8:0] addr_d;
    logic       last_beat;

    // Address wraps naturally at 9 bits; a fixed burst adds zero.
    assign addr_d    = addr_q + {8'd0, incr_q};
    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            incr_q      <= 1'b0;
            a_q         <= '0;
            wr_data_q   <= '0;
            rd_strobe_q <= 1'b0;
            wr_strobe_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rd_strobe_q <= 1'b0;
            wr_strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        len_q   <= cmd_len;
                        incr_q  <= cmd_incr;
                        cnt_q   <= '0;
                        state_q <= cmd_write ? WRITE : RD_ISSUE;
                    end
                end
                WRITE: begin
                    if (wdat_valid) begin
                        a_q         <= addr_q;
                        wr_data_q   <= wdat_data;
                        wr_strobe_q <= 1'b1;
                        addr_q      <= addr_d;
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                RD_ISSUE: begin
                    a_q         <= addr_q;
                    rd_strobe_q <= 1'b1;
                    state_q     <= RD_WAIT;
                end
                RD_WAIT: begin
                    // First cycle here is the strobe cycle; the responder drives d_q on the next one.
                    if (!rd_strobe_q) begin
                        rsp_data_q  <= d_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        addr_q      <= addr_d;
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 4'd1;
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign wdat_ready   = (state_q == WRITE);
    assign a            = a_q;
    assign d_d          = wr_data_q;
    assign read_strobe  = rd_strobe_q;
    assign write_strobe = wr_strobe_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_regbus_master.sv
// Randomized bench for regbus_master: register responder, transaction-level memory model and strobe monitor.
module tb_regbus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_incr;
    logic [8:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wdat_valid, wdat_ready;
    logic [7:0] wdat_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;
    logic [8:0] a;
    logic [7:0] d_d, d_q;
    logic       read_strobe, write_strobe;

    regbus_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .a(a), .d_d(d_d), .d_q(d_q),
        .read_strobe(read_strobe), .write_strobe(write_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Power-up register contents shared by the responder and the model.
    function automatic logic [7:0] init_val(input logic [8:0] ad);
        if (ad == 9'h000) return 8'h42;
        if (ad == 9'h001) return 8'h73;
        return 8'(ad) * 8'd7 + 8'h19;
    endfunction

    // Register responder: write on strobe, read data valid the cycle after read_strobe.
    bit   [7:0] resp_mem [512];
    bit         resp_wrt [512];
    logic [8:0] last_wr_addr;
    logic [7:0] last_wr_data;
    always @(posedge clk) begin
        if (write_strobe) begin
            resp_mem[a]  <= d_d;
            resp_wrt[a]  <= 1'b1;
            last_wr_addr <= a;
            last_wr_data <= d_d;
        end
        if (read_strobe)
            d_q <= resp_wrt[a] ? resp_mem[a] : init_val(a);
    end

    // Strobe monitor.
    int cyc = 0;
    int wr_a[$], wr_d[$], wr_c[$], rd_a[$], rd_c[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (write_strobe) begin
            wr_a.push_back(int'(a)); wr_d.push_back(int'(d_d)); wr_c.push_back(cyc);
        end
        if (read_strobe) begin
            rd_a.push_back(int'(a)); rd_c.push_back(cyc);
        end
        if (read_strobe || write_strobe)
            check("strobe_excl", 32'(read_strobe & write_strobe), 32'd0);
    end

    // Reference model: register contents as seen by completed write bursts.
    logic [7:0] ref_mem [512];
    logic [7:0] wq[$];
    int         acc_cyc;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [8:0] ad, input logic [3:0] ln, input logic inc);
        int t;
        t = 0;
        while (!cmd_ready && t < 100) begin step(); t++; end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = ad; cmd_len = ln; cmd_incr = inc;
        step();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 9'($urandom); cmd_len = 4'($urandom); cmd_incr = 1'($urandom);
        check("cmd_accept_busy", 32'(busy), 32'd1);
    endtask

    task automatic do_write(input logic [8:0] ad, input logic [3:0] ln, input logic inc, input int gapmax);
        int nw0, t, g;
        logic [8:0] ea;
        nw0 = wr_a.size();
        send_cmd(1'b1, ad, ln, inc);
        for (int b = 0; b <= int'(ln); b++) begin
            g = (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0));
            wdat_valid = 1'b0;
            repeat (g) begin
                step();
                check("wdat_ready_stall", 32'(wdat_ready), 32'd1);
            end
            wdat_valid = 1'b1;
            wdat_data  = wq[b];
            t = 0;
            while (!wdat_ready && t < 50) begin step(); t++; end
            step();
        end
        wdat_valid = 1'b0;
        wdat_data  = 8'($urandom);
        check("wr_end_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        check("wr_count", wr_a.size() - nw0, int'(ln) + 1);
        if (wr_a.size() - nw0 == int'(ln) + 1) begin
            ea = ad;
            for (int b = 0; b <= int'(ln); b++) begin
                check("wr_addr", wr_a[nw0 + b], 32'(ea));
                check("wr_data", wr_d[nw0 + b], 32'(wq[b]));
                if (gapmax == 0)
                    check("wr_cycle", wr_c[nw0 + b], acc_cyc + 1 + b);
                ref_mem[ea] = wq[b];
                ea = ea + 9'(inc);
            end
        end
    endtask

    task automatic do_read(input logic [8:0] ad, input logic [3:0] ln, input logic inc,
                           input int smin, input int smax);
        int nr0, t, s;
        logic [8:0] ea;
        logic [7:0] held;
        nr0 = rd_a.size();
        ea  = ad;
        send_cmd(1'b0, ad, ln, inc);
        for (int b = 0; b <= int'(ln); b++) begin
            t = 0;
            while (!rsp_valid && t < 50) begin step(); t++; end
            check("rsp_wait", 32'(rsp_valid), 32'd1);
            if (!rsp_valid) return;
            check("rd_strobes", rd_a.size() - nr0, b + 1);
            if (rd_a.size() - nr0 == b + 1) begin
                check("rd_addr", rd_a[nr0 + b], 32'(ea));
                check("rd_latency", cyc - rd_c[nr0 + b], 2);
            end
            check("rd_data", 32'(rsp_data), 32'(ref_mem[ea]));
            held      = rsp_data;
            s         = int'($urandom_range(smax, smin));
            rsp_ready = 1'b0;
            repeat (s) begin
                cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 9'($urandom);
                step();
                check("bp_valid", 32'(rsp_valid), 32'd1);
                check("bp_data", 32'(rsp_data), 32'(held));
                check("bp_no_strobe", rd_a.size() - nr0, b + 1);
                check("bp_busy", 32'(busy), 32'd1);
                check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check("rsp_clear", 32'(rsp_valid), 32'd0);
            ea = ea + 9'(inc);
        end
        check("rd_end_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int nw0, t;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(9'(i));
        rst_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_incr = 0;
        wdat_valid = 0; wdat_data = 0; rsp_ready = 0;

        // Reset with random inputs.
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = 9'($urandom);
            cmd_len = 4'($urandom); cmd_incr = 1'($urandom); wdat_valid = 1'($urandom);
            wdat_data = 8'($urandom); rsp_ready = 1'($urandom);
            step();
            check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_a", 32'(a), 32'd0);
            check("rst_d_d", 32'(d_d), 32'd0);
            check("rst_strobes", 32'({read_strobe, write_strobe}), 32'd0);
            check("rst_rsp", 32'({rsp_valid, rsp_data}), 32'd0);
            check("rst_wdat_ready", 32'(wdat_ready), 32'd0);
        end
        cmd_valid = 0; wdat_valid = 0; rsp_ready = 0;
        rst_n = 1'b1;
        step();

        // Single write then readback.
        wq = '{8'h5A};
        do_write(9'h002, 4'd0, 1'b1, 0);
        check("a_hold", 32'(a), 32'h002);
        do_read(9'h002, 4'd0, 1'b1, 0, 0);

        // Incrementing read burst over preset registers.
        do_read(9'h000, 4'd1, 1'b1, 0, 0);

        // Backpressure on a single read.
        do_read(9'h001, 4'd0, 1'b1, 5, 5);

        // Reset in the middle of a 16-beat write.
        wq.delete();
        for (int i = 0; i < 16; i++) wq.push_back(8'($urandom));
        nw0 = wr_a.size();
        send_cmd(1'b1, 9'h080, 4'hF, 1'b1);
        wdat_valid = 1'b1;
        t = 0;
        while (wr_a.size() - nw0 < 3 && t < 50) begin
            wdat_data = 8'($urandom);
            step();
            t++;
        end
        check("rst_mid_strobes", wr_a.size() - nw0, 3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ws", 32'(write_strobe), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_a", 32'(a), 32'd0);
        repeat (3) step();
        wdat_valid = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        check("rst_mid_no_more", wr_a.size() - nw0, 3);
        check("rst_mid_idle", 32'(cmd_ready), 32'd1);
        do_read(9'h000, 4'd0, 1'b1, 0, 0);

        // Full-length back-to-back write burst.
        wq.delete();
        for (int i = 0; i < 16; i++) wq.push_back(8'($urandom));
        do_write(9'h1A0, 4'hF, 1'b1, 0);
        do_read(9'h1A0, 4'hF, 1'b1, 0, 1);

        // Random bursts kept within 0x100..0x1FF.
        for (int n = 0; n < 40; n++) begin
            logic       w, inc;
            logic [8:0] ad;
            logic [3:0] ln;
            w   = 1'($urandom);
            inc = 1'($urandom);
            ad  = 9'h100 + 9'($urandom_range(240, 0));
            ln  = 4'($urandom);
            if (w) begin
                wq.delete();
                for (int i = 0; i <= int'(ln); i++) wq.push_back(8'($urandom));
                do_write(ad, ln, inc, int'($urandom_range(2, 0)));
            end else begin
                do_read(ad, ln, inc, 0, int'($urandom_range(3, 0)));
            end
        end

        // Address wrap at the top of the space.
        wq = '{8'h11, 8'h22, 8'h33};
        do_write(9'h1FF, 4'd2, 1'b1, 0);
        check("wrap_last_addr", 32'(last_wr_addr), 32'h001);
        check("wrap_last_data", 32'(last_wr_data), 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
